// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the RISC-V M extension.
// Accepts one op in IDLE, runs XLEN CALC steps, fixes sign in FIX, holds the result in DONE.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_d;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic              neg;

  logic            a_signed, b_signed, a_neg, b_neg, neg_in;
  logic            div_zero, div_ovf, fast, fire;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign a_neg    = a_signed && a[XLEN-1];
  assign b_neg    = b_signed && b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  // Remainder follows the dividend's sign; products and quotients take the XOR.
  assign neg_in   = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
  assign div_zero = op[2] && (b == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == '1);
  assign fast     = div_zero || div_ovf;
  assign fast_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
  assign fire     = (state == IDLE) && in_valid && !flush;

  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic [XLEN-1:0]   div_sel, fix_res;

  // Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, quotient}.
  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next  = {mul_sum, acc[XLEN-1:1]};
  assign div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
  assign div_next  = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  assign prod    = neg ? -acc : acc;
  assign div_sel = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
  assign fix_res = op_q[2]            ? (neg ? -div_sel : div_sel) :
                   (op_q == OP_MUL)   ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    // NOTE: default first, so no path leaves state_d unassigned and no latch is inferred.
    state_d = state;
    unique case (state)
      IDLE:    if (fire) state_d = fast ? DONE : CALC;
      CALC:    if (flush) state_d = IDLE;
               else if (cnt == LAST_CNT) state_d = FIX;
      FIX:     state_d = flush ? IDLE : DONE;
      DONE:    if (flush || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, so no stale operand survives an aborted op.
    if (!reset_n) begin
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      op_q   <= OP_MUL;
      neg    <= 1'b0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: if (fire) begin
          op_q <= op;
          neg  <= neg_in;
          cnt  <= '0;
          acc  <= {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
          opnd <= op[2] ? b_mag : a_mag;
          if (fast) result <= fast_res;
        end
        CALC: begin
          acc <= op_q[2] ? div_next : mul_next;
          cnt <= cnt + CNT_W'(1);
        end
        FIX:  if (!flush) result <= fix_res;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed table, hand-written
// handshake/flush/reset sequences, and random ops against an arithmetic reference.
module tb_muldiv_unit;

  localparam int XLEN     = 32;
  localparam int FULL_LAT = XLEN + 2;

  logic            clk = 1'b0;
  logic            reset_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b, result;

  int n_vec     = 0;
  int n_err     = 0;
  int both_high = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .op(op), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always @(negedge clk) if (in_ready && out_valid) both_high++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no summary, want completion");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] e, input int l);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.exp = e; v.lat = l;
    return v;
  endfunction

  // Reference: plain 64-bit / signed integer arithmetic on the operation definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    logic [63:0] sx, zx, sy, zy, p;
    logic [31:0] r;
    sx = {{32{x[31]}}, x}; zx = {32'b0, x};
    sy = {{32{y[31]}}, y}; zy = {32'b0, y};
    r  = '0;
    case (o)
      3'd0: begin p = zx * zy; r = p[31:0];  end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * zy; r = p[63:32]; end
      3'd3: begin p = zx * zy; r = p[63:32]; end
      3'd4: if (y == 0) r = '1;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
            else r = $signed(x) / $signed(y);
      3'd5: r = (y == 0) ? '1 : x / y;
      3'd6: if (y == 0) r = x;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = '0;
            else r = $signed(x) % $signed(y);
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && y == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return FULL_LAT;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Starts and ends on a falling edge; lat = edges from accept until out_valid is sampled high.
  task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, output logic [31:0] r, output int lat);
    check({name, " in_ready before issue"}, {31'b0, in_ready}, 32'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    lat = 0;
    for (int c = 1; c <= 2 * FULL_LAT; c++) begin
      if (out_valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    r = result;
  endtask

  task automatic release_op(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " in_ready after release"},  {31'b0, in_ready},  32'd1);
    check({name, " out_valid after release"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int          lat;
    int          seen;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset in_ready",  {31'b0, in_ready},  32'd1);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset busy",      {31'b0, busy},      32'd0);
    check("reset result",    result,             32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    vecs.push_back(mk(3'd0, 32'd7,         32'd6,         32'd42,        34));
    vecs.push_back(mk(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34));
    vecs.push_back(mk(3'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 34));
    vecs.push_back(mk(3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 34));
    vecs.push_back(mk(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34));
    vecs.push_back(mk(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34));
    vecs.push_back(mk(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34));
    vecs.push_back(mk(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34));
    vecs.push_back(mk(3'd5, 32'd100,       32'd7,         32'd14,        34));
    vecs.push_back(mk(3'd7, 32'd100,       32'd7,         32'd2,         34));
    vecs.push_back(mk(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34));
    vecs.push_back(mk(3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1));
    vecs.push_back(mk(3'd6, 32'd5,         32'd0,         32'd5,         1));
    vecs.push_back(mk(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1));
    vecs.push_back(mk(3'd7, 32'd5,         32'd0,         32'd5,         1));
    vecs.push_back(mk(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1));
    vecs.push_back(mk(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1));

    for (int i = 0; i < vecs.size(); i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, r, lat);
      check($sformatf("vec%0d result", i),  r,   vecs[i].exp);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      release_op($sformatf("vec%0d", i));
    end

    // Backpressure: result must hold while out_ready stays low, then a back-to-back op.
    do_op("bp", 3'd0, 32'd123, 32'd456, r, lat);
    check("bp result", r, 32'd56088);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp hold result",    result,             32'd56088);
      check("bp hold in_ready",  {31'b0, in_ready},  32'd0);
      check("bp hold out_valid", {31'b0, out_valid}, 32'd1);
    end
    release_op("bp");
    do_op("b2b", 3'd5, 32'd1000, 32'd3, r, lat);
    check("b2b result",  r,   32'd333);
    check("b2b latency", lat, FULL_LAT);
    release_op("b2b");

    // Flush in the tenth CALC cycle: discarded result never appears, old result kept.
    op = 3'd0; a = 32'd9; b = 32'd9; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("flush busy before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy",      {31'b0, busy},      32'd0);
    check("flush in_ready",  {31'b0, in_ready},  32'd1);
    check("flush out_valid", {31'b0, out_valid}, 32'd0);
    check("flush result",    result,             32'd333);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush no out_valid", seen, 0);

    // Reset in the middle of CALC.
    op = 3'd3; a = 32'hDEAD_BEEF; b = 32'h1234_5678; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset in_ready",  {31'b0, in_ready},  32'd1);
    check("midreset out_valid", {31'b0, out_valid}, 32'd0);
    check("midreset busy",      {31'b0, busy},      32'd0);
    check("midreset result",    result,             32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // flush together with in_valid in IDLE: nothing is accepted, not even a fast path.
    op = 3'd4; a = 32'd5; b = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("idle flush out_valid", {31'b0, out_valid}, 32'd0);
    check("idle flush busy",      {31'b0, busy},      32'd0);
    check("idle flush in_ready",  {31'b0, in_ready},  32'd1);

    // Random ops against the arithmetic reference, biased towards corner operands.
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  o;
      logic [31:0] x, y;
      o = 3'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = $urandom_range(0, 15);
        3: x = $urandom_range(0, 15);
        4: y = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_op($sformatf("rand%0d", i), o, x, y, r, lat);
      check($sformatf("rand%0d op%0d a=%08h b=%08h result", i, o, x, y), r, ref_result(o, x, y));
      check($sformatf("rand%0d op%0d latency", i, o), lat, ref_lat(o, x, y));
      release_op($sformatf("rand%0d", i));
    end

    check("in_ready/out_valid overlap cycles", both_high, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
